bit_result_stage: RTL

BIT_RESULT_STAGE -- requirements
Module: bit_result_stage

---
 rtl/bit_result_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/bit_result_stage.sv
// Two-entry in-order result buffer between the bit ALU and writeback,
// with combinational register forwarding from the buffered entries.
module bit_result_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_res,
  input  logic [4:0]  in_waddr,
  input  logic        in_wren,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [4:0]  out_waddr,
  output logic        out_wren,
  input  logic [4:0]  fwd_raddr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [1:0]  count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;

  // Slot 0 is always the head; slot 1 is only valid in FULL.
  logic [31:0] res0, res1;
  logic [4:0]  waddr0, waddr1;
  logic        wren0, wren1;

  logic push, pop, cap_wren;
  logic hit0, hit1;

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign cap_wren = in_wren & (in_waddr != '0);

  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (pop && !push) state_nxt = EMPTY;
        end
        FULL:  if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      res0   <= '0;
      res1   <= '0;
      waddr0 <= '0;
      waddr1 <= '0;
      wren0  <= 1'b0;
      wren1  <= 1'b0;
    end else if (!flush) begin
      // In ONE a push lands in slot 0 if the head leaves this cycle, else slot 1.
      if (push && (state == EMPTY || (state == ONE && pop))) begin
        res0   <= in_res;
        waddr0 <= in_waddr;
        wren0  <= cap_wren;
      end else if (push && state == ONE) begin
        res1   <= in_res;
        waddr1 <= in_waddr;
        wren1  <= cap_wren;
      end else if (pop && state == FULL) begin
        res0   <= res1;
        waddr0 <= waddr1;
        wren0  <= wren1;
      end
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    out_res   = out_valid ? res0   : '0;
    out_waddr = out_valid ? waddr0 : '0;
    out_wren  = out_valid ? wren0  : 1'b0;
    unique case (state)
      EMPTY:   count = 2'd0;
      ONE:     count = 2'd1;
      FULL:    count = 2'(DEPTH);
      default: count = 2'd0;
    endcase
  end

  // The younger entry (slot 1) wins when both match.
  always_comb begin
    hit0     = (state != EMPTY) && wren0 && (waddr0 == fwd_raddr) && (fwd_raddr != '0);
    hit1     = (state == FULL)  && wren1 && (waddr1 == fwd_raddr) && (fwd_raddr != '0);
    fwd_hit  = hit0 | hit1;
    fwd_data = '0;
    if (hit1)      fwd_data = res1;
    else if (hit0) fwd_data = res0;
  end

endmodule
